plru_way_arbiter: RTL
=====================

PLRU_WAY_ARBITER -- requirements
Module: plru_way_arbiter

Interface
REQ-001 SHALL have parameter WAYS, default 4, meaning associativity; legal values 2, 4, 8.
REQ-002 SHALL have parameter SETS, default 8, meaning sets tracked; power of 2, >=2.
REQ-003 SHALL define WB = log2(WAYS) and IB = log2(SETS) as derived widths.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port index, input, IB bits: set being accessed.
REQ-007 SHALL have port way_sel, input, WB bits: hit way from tag compare.
REQ-008 SHALL have port lru_or_way, input, 1 bit: 0 = target victim (miss/fill); 1 = target way_sel (hit).
REQ-009 SHALL have port valid_mask, input, WAYS bits: valid bits of the ways in set index.
REQ-010 SHALL have port load_req, input, 1 bit: request a data/tag array write this cycle.
REQ-011 SHALL have port touch, input, 1 bit: mark the target way most-recently-used.
REQ-012 SHALL have port load, output, WAYS bits: one-hot array load enables.
REQ-013 SHALL have port victim, output, WB bits: replacement way for set index.

Function
REQ-014 SHALL hold WAYS-1 tree-PLRU bits per set in a SETS-entry register array.
REQ-015 Node numbering SHALL be heap order (root = node 0; children of n = 2n+1, 2n+2); node bit 0 SHALL mean the victim is in the lower-numbered half.
REQ-016 victim SHALL be combinational from current state: if valid_mask has any zero bit, the lowest-numbered invalid way; otherwise the way reached by walking the tree of set index.
REQ-017 target SHALL be way_sel when lru_or_way = 1, else victim.
REQ-018 load SHALL be the one-hot of target when load_req = 1, else all zeros; exactly one bit high when load_req = 1.
REQ-019 On a clk edge with touch = 1, every node on the path to target in set index SHALL be set to point away from target; nodes off the path and other sets SHALL be unchanged.
REQ-020 Latency: a touch SHALL affect victim from the cycle after the edge; in the touch cycle victim and load SHALL reflect pre-update state.
REQ-021 touch with load_req = 0 SHALL update state with load = 0; load_req without touch SHALL leave state unchanged.
REQ-022 Back-to-back touches to the same set on consecutive cycles SHALL each apply to the state left by the previous one; none are dropped.
REQ-023 With WAYS = 2, behaviour SHALL reduce to one LRU bit per set: victim = bit, and touching way w sets the bit to ~w.
REQ-024 way_sel outside 0..WAYS-1 cannot occur, since WB exactly covers WAYS; no range check is required.

Reset
REQ-025 When reset = 1 at a clk edge, all PLRU bits of all sets SHALL clear to 0, giving victim = 0 with all ways valid; reset SHALL take priority over a simultaneous touch.
REQ-026 During reset, load SHALL still follow REQ-018 combinationally; a touch asserted mid-reset SHALL be discarded.
REQ-027 The block SHALL have no other state.

Verification
REQ-028 Scenario: WAYS=4, reset, index=3, valid_mask=1111 -> victim=0; lru_or_way=0, load_req=1 -> load=0001.
REQ-029 Scenario: WAYS=4, set 3, touches on ways 0, 2, 1 in sequence (lru_or_way=1) -> victim reads 2, then 1, then 3 after each edge; set 2 stays at victim=0.
REQ-030 Scenario: valid_mask=1011 after those touches -> victim=2, overriding PLRU; load_req=1, lru_or_way=0 -> load=0100.
REQ-031 Scenario: lru_or_way=1, way_sel=3, load_req=1, touch=1 on a set whose victim=3 -> load=1000 that cycle, victim=3 that cycle, victim=1 next cycle.
REQ-032 Scenario: touch=1 and reset=1 on the same edge -> all sets read victim=0 the following cycle.
REQ-033 Scenario: WAYS=2 build; touch way 0 -> victim=1; touch way 1 -> victim=0; load_req=0 -> load=00.

Source files
------------

// File: rtl/plru_way_arbiter.sv
// Tree pseudo-LRU replacement state for a set-associative cache, with victim selection
// that prefers invalid ways and one-hot array load enables for the chosen way.
module plru_way_arbiter #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 8,
    localparam int unsigned WB = $clog2(WAYS),
    localparam int unsigned IB = $clog2(SETS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IB-1:0]   index,
    input  logic [WB-1:0]   way_sel,
    input  logic            lru_or_way,
    input  logic [WAYS-1:0] valid_mask,
    input  logic            load_req,
    input  logic            touch,
    output logic [WAYS-1:0] load,
    output logic [WB-1:0]   victim
);

    localparam int unsigned Nodes = WAYS - 1;

    // Heap-ordered tree per set; a node bit of 0 points the victim into the lower half.
    logic [Nodes-1:0] plru_q [SETS];
    logic [Nodes-1:0] plru_d [SETS];

    logic [Nodes-1:0] cur_bits;
    logic [Nodes-1:0] upd_bits;
    logic [WB-1:0]    tree_way;
    logic [WB-1:0]    inv_way;
    logic             has_inv;
    logic [WB-1:0]    target;

    assign cur_bits = plru_q[index];

    // Walk the tree from the root following each node's pointer down to a leaf.
    always_comb begin
        int unsigned node;
        node = 0;
        for (int l = 0; l < int'(WB); l++) begin
            if (cur_bits[node]) begin
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
        end
        tree_way = WB'(node - Nodes);
    end

    // Lowest-numbered invalid way wins, so scan from the top down.
    always_comb begin
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_mask[w]) begin
                has_inv = 1'b1;
                inv_way = WB'(w);
            end
        end
    end

    always_comb begin
        victim = has_inv ? inv_way : tree_way;
        target = lru_or_way ? way_sel : victim;
        load   = '0;
        if (load_req) begin
            load[target] = 1'b1;
        end
    end

    // Each node on the target's path is pointed at the opposite subtree.
    always_comb begin
        int unsigned node;
        logic        dir;
        upd_bits = cur_bits;
        node     = 0;
        for (int l = 0; l < int'(WB); l++) begin
            dir            = target[int'(WB) - 1 - l];
            upd_bits[node] = ~dir;
            node           = 2 * node + 1 + 32'(dir);
        end
    end

    always_comb begin
        plru_d = plru_q;
        if (touch) begin
            plru_d[index] = upd_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SETS); s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            plru_q <= plru_d;
        end
    end

endmodule
